// File: rtl/matrix_mem_bank_if.sv
// Request/response bundle for matrix_mem_bank: address, write data, strobes in; read data and status out.
interface matrix_mem_bank_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ELEM_W = 16
) ();
    localparam int unsigned NELEM = DATA_W / ELEM_W;

    logic [15:0]       address;
    logic [DATA_W-1:0] DataIn;
    logic [NELEM-1:0]  ElemMask;
    logic              nRead;
    logic              nWrite;
    logic              nClear;
    logic [DATA_W-1:0] DataOut;
    logic              DataValid;
    logic              Busy;
    logic              AddrErr;

    modport master (
        output address, DataIn, ElemMask, nRead, nWrite, nClear,
        input  DataOut, DataValid, Busy, AddrErr
    );

    modport slave (
        input  address, DataIn, ElemMask, nRead, nWrite, nClear,
        output DataOut, DataValid, Busy, AddrErr
    );
endinterface

// File: rtl/matrix_mem_bank.sv
// Matrix row memory with per-element write mask, READ_LAT-deep read pipeline and bulk-clear engine.
// Optional macro MEM_RD_BYPASS_EN: same-cycle read+write forwards the merged write row to the read.
module matrix_mem_bank #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ELEM_W    = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MODULE_ID = 0,
    parameter int unsigned READ_LAT  = 1,
    parameter logic [255:0] INIT0 =
        256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010,
    parameter logic [255:0] INIT1 =
        256'h0020_001f_001e_001d_001c_001b_001a_0019_0018_0017_0016_0015_0014_0013_0012_0011
) (
    input  logic              Clk,
    input  logic              nReset,
    matrix_mem_bank_if.slave  bus
);
    localparam int unsigned NELEM = DATA_W / ELEM_W;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] INIT0_W = DATA_W'(INIT0);
    localparam logic [DATA_W-1:0] INIT1_W = DATA_W'(INIT1);
    localparam logic [AW-1:0]     LAST_ROW = AW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [READ_LAT];

    logic              claim_c;
    logic              in_range_c;
    logic              access_c;
    logic              rd_en_c;
    logic              wr_en_c;
    logic              clr_en_c;
    logic [AW-1:0]     row_c;
    logic [DATA_W-1:0] old_row_c;
    logic [DATA_W-1:0] merged_row_c;
    logic [DATA_W-1:0] rd_data_c;

    // Address decode and access qualification; the bank ignores the bus while clearing.
    always_comb begin
        claim_c    = (bus.address[15:12] == 4'(MODULE_ID));
        in_range_c = (32'(bus.address[11:0]) < DEPTH);
        row_c      = AW'(bus.address[11:0]);
        access_c   = (state_q == ST_IDLE) && claim_c && (!bus.nRead || !bus.nWrite);
        rd_en_c    = access_c && in_range_c && !bus.nRead;
        wr_en_c    = access_c && in_range_c && !bus.nWrite;
    end

    // Element-masked merge of the incoming write into the addressed row.
    always_comb begin
        old_row_c    = mem_q[row_c];
        merged_row_c = old_row_c;
        for (int i = 0; i < int'(NELEM); i++) begin
            if (bus.ElemMask[i]) begin
                merged_row_c[i*ELEM_W +: ELEM_W] = bus.DataIn[i*ELEM_W +: ELEM_W];
            end
        end
`ifdef MEM_RD_BYPASS_EN
        rd_data_c = wr_en_c ? merged_row_c : old_row_c;
`else
        rd_data_c = old_row_c;
`endif
    end

    // Clear engine next-state: one row zeroed per cycle, DEPTH cycles total.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        err_d    = access_c && !in_range_c;
        clr_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.nClear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_en_c = 1'b1;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Row storage; writes and clears never coincide because writes need the idle state.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem_q[r] <= (r == 0) ? INIT0_W : ((r == 1) ? INIT1_W : '0);
            end
        end else if (clr_en_c) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en_c) begin
            mem_q[row_c] <= merged_row_c;
        end
    end

    // Read pipeline: stages only load on a valid beat so the last stage holds between pulses.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            vld_q <= '0;
            for (int k = 0; k < int'(READ_LAT); k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en_c;
            if (rd_en_c) begin
                dat_q[0] <= rd_data_c;
            end
            for (int k = 1; k < int'(READ_LAT); k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign bus.DataOut   = dat_q[READ_LAT-1];
    assign bus.DataValid = vld_q[READ_LAT-1];
    assign bus.Busy      = busy_q;
    assign bus.AddrErr   = err_q;

endmodule

// File: tb/tb_matrix_mem_bank.sv
// Directed + randomized bench for matrix_mem_bank (READ_LAT=1 and READ_LAT=3 instances) against a row-level model.
module tb_matrix_mem_bank;
    localparam int DW    = 256;
    localparam int EW    = 16;
    localparam int NE    = 16;
    localparam int DEPTH = 16;

    logic          Clk;
    logic          nReset;
    logic [15:0]   drv_addr;
    logic [DW-1:0] drv_din;
    logic [NE-1:0] drv_mask;
    logic          drv_nr, drv_nw, drv_nc;

    matrix_mem_bank_if #(.DATA_W(DW), .ELEM_W(EW)) b1 ();
    matrix_mem_bank_if #(.DATA_W(DW), .ELEM_W(EW)) b3 ();

    assign b1.address  = drv_addr;
    assign b1.DataIn   = drv_din;
    assign b1.ElemMask = drv_mask;
    assign b1.nRead    = drv_nr;
    assign b1.nWrite   = drv_nw;
    assign b1.nClear   = drv_nc;
    assign b3.address  = drv_addr;
    assign b3.DataIn   = drv_din;
    assign b3.ElemMask = drv_mask;
    assign b3.nRead    = drv_nr;
    assign b3.nWrite   = drv_nw;
    assign b3.nClear   = drv_nc;

    matrix_mem_bank #(.READ_LAT(1)) u_dut1 (.Clk(Clk), .nReset(nReset), .bus(b1.slave));
    matrix_mem_bank #(.READ_LAT(3)) u_dut3 (.Clk(Clk), .nReset(nReset), .bus(b3.slave));

    always #5 Clk = ~Clk;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } pend_t;

    logic [DW-1:0] mdl [DEPTH];
    pend_t         q1[$];
    pend_t         q3[$];
    int            cyc;
    int            busy_left;
    logic          exp_v1, exp_v3, exp_err, exp_busy;
    logic [DW-1:0] exp_d1, exp_d3;
    int            n_cmp, n_fail;
    int            busy_cnt;

    localparam logic [DW-1:0] INIT0_LIT =
        256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
    localparam logic [DW-1:0] INIT1_LIT =
        256'h0020_001f_001e_001d_001c_001b_001a_0019_0018_0017_0016_0015_0014_0013_0012_0011;

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        return {NE{v}};
    endfunction

    function automatic logic [DW-1:0] init_row(input int r);
        logic [DW-1:0] v;
        v = '0;
        for (int e = 0; e < NE; e++) begin
            if (r == 0) v[e*EW +: EW] = 16'(16 - e);
            else if (r == 1) v[e*EW +: EW] = 16'(17 + e);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) mdl[r] = init_row(r);
        q1.delete();
        q3.delete();
        busy_left = 0;
        exp_v1 = 1'b0; exp_v3 = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        exp_d1 = '0;   exp_d3 = '0;
    endtask

    // Row-level behaviour at one rising edge, from the inputs the bench is holding.
    task automatic model_edge();
        int            row;
        logic [DW-1:0] old_v, new_v, rd_v;
        cyc++;
        exp_err = 1'b0;
        if (!nReset) begin
            model_reset();
            return;
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) for (int r = 0; r < DEPTH; r++) mdl[r] = '0;
        end else begin
            row = int'(drv_addr[11:0]);
            if (drv_addr[15:12] == 4'd0 && (!drv_nr || !drv_nw)) begin
                if (row >= DEPTH) begin
                    exp_err = 1'b1;
                end else begin
                    old_v = mdl[row];
                    new_v = old_v;
                    for (int e = 0; e < NE; e++)
                        if (drv_mask[e]) new_v[e*EW +: EW] = drv_din[e*EW +: EW];
                    rd_v = old_v;
`ifdef MEM_RD_BYPASS_EN
                    if (!drv_nw) rd_v = new_v;
`endif
                    if (!drv_nr) begin
                        q1.push_back('{cyc, rd_v});
                        q3.push_back('{cyc + 2, rd_v});
                    end
                    if (!drv_nw) mdl[row] = new_v;
                end
            end
            if (!drv_nc) busy_left = DEPTH;
        end
        exp_busy = (busy_left > 0);
        exp_v1 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            exp_v1 = 1'b1; exp_d1 = q1[0].d; void'(q1.pop_front());
        end
        exp_v3 = 1'b0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            exp_v3 = 1'b1; exp_d3 = q3[0].d; void'(q3.pop_front());
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_val);
        n_cmp++;
        assert (obs === exp_val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_val);
        end
    endtask

    task automatic check_all();
        chk("valid_l1", DW'(b1.DataValid), DW'(exp_v1));
        chk("data_l1",  b1.DataOut,        exp_d1);
        chk("err_l1",   DW'(b1.AddrErr),   DW'(exp_err));
        chk("busy_l1",  DW'(b1.Busy),      DW'(exp_busy));
        chk("valid_l3", DW'(b3.DataValid), DW'(exp_v3));
        chk("data_l3",  b3.DataOut,        exp_d3);
        chk("err_l3",   DW'(b3.AddrErr),   DW'(exp_err));
        chk("busy_l3",  DW'(b3.Busy),      DW'(exp_busy));
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        drv_nr = 1'b1; drv_nw = 1'b1; drv_nc = 1'b1;
    endtask

    task automatic op(input logic [15:0] a, input logic [DW-1:0] d, input logic [NE-1:0] m,
                      input logic nr, input logic nw, input logic nc);
        drv_addr = a; drv_din = d; drv_mask = m;
        drv_nr = nr; drv_nw = nw; drv_nc = nc;
        tick();
        idle();
    endtask

    // Asynchronous reset pulse placed mid-cycle, held across one edge.
    task automatic async_reset();
        #2;
        nReset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset_valid_now", DW'(b3.DataValid), '0);
        idle();
        tick();
        nReset = 1'b1;
    endtask

    initial begin
        Clk = 1'b0; nReset = 1'b1; cyc = 0; n_cmp = 0; n_fail = 0;
        drv_addr = '0; drv_din = '0; drv_mask = '0;
        idle();
        model_reset();
        #1 nReset = 1'b0;
        #1 check_all();
        #15 nReset = 1'b1;

        // Reset contents
        op(16'h0000, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("row0_init", b1.DataOut, INIT0_LIT);
        op(16'h0001, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("row1_init", b1.DataOut, INIT1_LIT);
        op(16'h0005, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("row5_init", b1.DataOut, '0);
        repeat (3) tick();

        // Element-masked write
        op(16'h0003, rep(16'h5555), 16'hFFFF, 1'b1, 1'b0, 1'b1);
        op(16'h0003, rep(16'hAAAA), 16'h00FF, 1'b1, 1'b0, 1'b1);
        op(16'h0003, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("mask_merge", b1.DataOut, {{8{16'h5555}}, {8{16'hAAAA}}});
        op(16'h0003, rep(16'h7777), 16'h0000, 1'b1, 1'b0, 1'b1);
        op(16'h0003, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("mask_zero_noop", b1.DataOut, {{8{16'h5555}}, {8{16'hAAAA}}});
        repeat (3) tick();

        // Out-of-range and unclaimed accesses
        op(16'h0010, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("oor_err", DW'(b1.AddrErr), DW'(1'b1));
        chk("oor_no_valid", DW'(b1.DataValid), '0);
        op(16'h0013, rep(16'hDEAD), 16'hFFFF, 1'b0, 1'b0, 1'b1);
        op(16'h1003, rep(16'h0BAD), 16'hFFFF, 1'b1, 1'b0, 1'b1);
        chk("unclaimed_no_err", DW'(b1.AddrErr), '0);
        op(16'h0003, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("unclaimed_unchanged", b1.DataOut, {{8{16'h5555}}, {8{16'hAAAA}}});
        repeat (3) tick();

        // Bulk clear with a same-cycle read and accesses issued while busy
        op(16'h0002, '0, '0, 1'b0, 1'b1, 1'b0);
        busy_cnt = b1.Busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            drv_addr = 16'(i % 4); drv_din = rep(16'hFFFF); drv_mask = 16'hFFFF;
            drv_nr = (i >= 16); drv_nw = (i >= 16); drv_nc = (i >= 10);
            tick();
            if (b1.Busy) busy_cnt++;
        end
        idle();
        chk("busy_len", DW'(busy_cnt), DW'(DEPTH));
        op(16'h0000, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("row0_cleared", b1.DataOut, '0);
        op(16'h0001, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("row1_cleared", b1.DataOut, '0);
        repeat (3) tick();

        // Same-cycle read and write to one row
        op(16'h0002, rep(16'h0BEE), 16'hFFFF, 1'b1, 1'b0, 1'b1);
        op(16'h0002, rep(16'h1234), 16'hFFFF, 1'b0, 1'b0, 1'b1);
`ifdef MEM_RD_BYPASS_EN
        chk("rw_same_row", b1.DataOut, rep(16'h1234));
`else
        chk("rw_same_row", b1.DataOut, rep(16'h0BEE));
`endif
        op(16'h0002, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("rw_after", b1.DataOut, rep(16'h1234));
        repeat (3) tick();

        // Three-cycle pipeline, back-to-back reads of rows 0..3
        async_reset();
        for (int r = 0; r < 4; r++) begin
            drv_addr = 16'(r); drv_nr = 1'b0;
            tick();
            if (r == 1) chk("lat3_not_yet", DW'(b3.DataValid), '0);
            if (r == 2) chk("lat3_first", b3.DataOut, INIT0_LIT);
        end
        idle();
        repeat (4) tick();

        // Reset in the middle of a read stream
        for (int r = 0; r < 3; r++) begin
            drv_addr = 16'(r); drv_nr = 1'b0;
            tick();
        end
        async_reset();
        repeat (4) tick();
        op(16'h0003, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("row3_reinit", b1.DataOut, '0);

        // Reset in the middle of a clear
        op(16'h0000, '0, '0, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        async_reset();
        op(16'h0000, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("clear_abort_row0", b1.DataOut, INIT0_LIT);
        repeat (3) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drv_addr = {(($urandom_range(0, 9) == 0) ? 4'h1 : 4'h0), 12'($urandom_range(0, 19))};
            for (int w = 0; w < DW / 32; w++) drv_din[w*32 +: 32] = $urandom;
            drv_mask = 16'($urandom);
            drv_nr   = 1'($urandom_range(0, 1));
            drv_nw   = 1'($urandom_range(0, 1));
            drv_nc   = ($urandom_range(0, 79) != 0);
            tick();
        end
        idle();
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_mem_bank.md
Name: matrix_mem_bank

Overview:
- Parametrised next-generation matrix main memory: DEPTH rows of DATA_W bits, each row one 4x4 (or larger) matrix of ELEM_W-bit elements.
- Adds per-element write masking, a configurable read pipeline with valid strobe, out-of-range address detection, and a sequential bulk-clear engine.
- Sits on the shared 16-bit address bus; claims accesses whose module-select field matches MODULE_ID.

Parameters:
- DATA_W, 256, row width in bits; must be a multiple of ELEM_W.
- ELEM_W, 16, element width; NELEM = DATA_W/ELEM_W.
- DEPTH, 16, number of rows; legal 2..4096.
- MODULE_ID, 0, value of address[15:12] that selects this bank.
- READ_LAT, 1, read latency in cycles; legal 1..3.
- INIT0, 256'h0001_0002_..._0010, reset contents of row 0 (zero-extended or truncated to DATA_W).
- INIT1, 256'h0020_001f_..._0011, reset contents of row 1; rows 2..DEPTH-1 reset to 0.

Ports:
- Clk  in  1  clock, all state on rising edge.
- nReset  in  1  asynchronous active-low reset.
- address  in  16  [15:12] module select, [11:0] row index.
- DataIn  in  DATA_W  write data.
- ElemMask  in  NELEM  per-element write enable, bit i covers DataIn[i*ELEM_W +: ELEM_W].
- nRead  in  1  active-low read request, sampled each cycle.
- nWrite  in  1  active-low write request, sampled each cycle.
- nClear  in  1  active-low bulk-clear start.
- DataOut  out  DATA_W  read data.
- DataValid  out  1  one-cycle pulse, DataOut valid.
- Busy  out  1  clear engine active.
- AddrErr  out  1  one-cycle pulse, rejected access.

Behaviour:
- Reset (async, nReset=0): rows 0/1 = INIT0/INIT1, others 0; DataOut=0, DataValid=0, Busy=0, AddrErr=0; read pipeline flushed; FSM -> IDLE. Reset mid-clear aborts the clear and re-initialises memory.
- Select: access is claimed only when address[15:12]==MODULE_ID. Unclaimed cycles change nothing, except that in-flight reads still drain.
- Range: claimed access with row index >= DEPTH -> access suppressed, AddrErr=1 on the next cycle (once per cycle, even if read and write are both low).
- Write: nWrite=0 and claimed, in range -> at the edge, row[idx] element i <= DataIn element i for each ElemMask[i]=1; unmasked elements are kept. ElemMask=0 is a legal no-op.
- Read: nRead=0 and claimed, in range -> row captured at the edge. DataOut/DataValid appear READ_LAT cycles after the request edge. Back-to-back reads are fully pipelined, one per cycle. DataOut holds its last value between valid pulses.
- Same-cycle read+write, same row: read returns the pre-write contents (read-before-write), unless MEM_RD_BYPASS_EN is defined.
- Different rows in the same cycle: both occur independently.
- FSM states:
  - IDLE: nClear=0 -> CLEAR, counter=0, Busy=1 from the next cycle.
  - CLEAR: row[counter] <= 0 each cycle, counter++. At counter==DEPTH-1 -> IDLE and Busy=0 the following cycle. Total Busy duration is DEPTH cycles.
- While Busy:
  - nRead/nWrite are ignored: no DataValid, no AddrErr, no memory update.
  - nClear is ignored.
  - Reads issued before the clear started still complete with their captured data.
- nClear asserted in the same cycle as a read/write: the access executes first, then the clear starts.
- Counter width is clog2(DEPTH) and never exceeds DEPTH-1.

Optional Feature:
- Macro MEM_RD_BYPASS_EN.
- Defined: same-cycle read and write to the same row forwards the merged write data (masked elements from DataIn, rest from the old row) to the read pipeline.
- Undefined: read-before-write, returning old contents.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then read row 0 with READ_LAT=1 -> DataValid pulses 1 cycle later, DataOut = 256'h0001_0002_..._0010; row 1 reads INIT1; row 5 reads 0.
- Write row 3 with DataIn all 16'hAAAA and ElemMask=16'h00FF, prior row all 16'h5555 -> read gives low 8 elements AAAA, high 8 elements 5555.
- Read row 16 with DEPTH=16, and write address 16'h1003 with MODULE_ID=0 -> first: AddrErr pulse, no DataValid; second: no AddrErr, memory unchanged.
- Pulse nClear, then issue reads during Busy -> Busy high exactly 16 cycles, reads ignored; afterwards row 0 and row 1 read 0.
- Same-cycle write 16'h1234 (all elements) and read to row 2 -> old value without macro, 16'h1234 pattern with MEM_RD_BYPASS_EN.
- READ_LAT=3 with four back-to-back reads of rows 0-3 -> four consecutive DataValid cycles starting 3 cycles after the first request. Assert nReset mid-stream -> DataValid=0 immediately, no further pulses.
